instr_fetch_unit: RTL

//  Parametrised fetch stage for the multi-cycle MIPS core. Holds a loadable instruction memory and

---
 rtl/instr_fetch_unit_pkg.sv | 21 ++
 rtl/instr_fetch_unit_skid_fifo2.sv | 61 ++++++
 rtl/instr_fetch_unit.sv | 120 ++++++++++++
 3 files changed

// File: rtl/instr_fetch_unit_pkg.sv
// Shared fetch definitions: reset PC, NOP word, fetch run/halt state and the
// core control-state encoding (IF is the state in which control raises fetch_en).
package instr_fetch_unit_pkg;

  localparam int unsigned RESET_PC = 0;
  localparam logic [31:0] NOP_WORD = 32'h0000_0000;

  typedef enum logic {
    FETCH_RUN  = 1'b0,
    FETCH_HALT = 1'b1
  } fetch_state_e;

  typedef enum logic [2:0] {
    CTRL_IF  = 3'd0,
    CTRL_ID  = 3'd1,
    CTRL_EX  = 3'd2,
    CTRL_MEM = 3'd3,
    CTRL_WB  = 3'd4
  } ctrl_state_e;

endpackage

// File: rtl/instr_fetch_unit_skid_fifo2.sv
// fetch_skid_fifo2: 2-entry shift FIFO; slot0 is always the head so the
// presented word stays stable until it is popped.
module fetch_skid_fifo2 #(
  parameter int unsigned W = 35
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  input  logic         flush,
  output logic [W-1:0] dout,
  output logic [1:0]   count
);

  logic [W-1:0] slot0;
  logic [W-1:0] slot1;
  logic [1:0]   cnt;
  logic         do_push;
  logic         do_pop;

  always_comb begin
    do_push = push && (cnt != 2'd2);
    do_pop  = pop && (cnt != 2'd0);
    dout    = slot0;
    count   = cnt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      slot0 <= '0;
      slot1 <= '0;
      cnt   <= '0;
    end else if (flush) begin
      cnt <= '0;
    end else begin
      case ({do_push, do_pop})
        2'b10: begin
          if (cnt == 2'd0) slot0 <= din;
          else             slot1 <= din;
          cnt <= cnt + 2'd1;
        end
        2'b01: begin
          slot0 <= slot1;
          cnt   <= cnt - 2'd1;
        end
        2'b11: begin
          // Simultaneous push/pop: new word lands behind whatever remains.
          if (cnt == 2'd1) begin
            slot0 <= din;
          end else begin
            slot0 <= slot1;
            slot1 <= din;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: loadable instruction memory, own PC, valid/ready output with
// redirect and program-length halt. Define SKID_BUF_EN for the 2-entry skid buffer.
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned IMEM_DEPTH = 8,
  parameter int unsigned PC_W       = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fetch_en,
  input  logic [PC_W:0]     prog_len,
  input  logic              imem_we,
  input  logic [PC_W-1:0]   imem_waddr,
  input  logic [DATA_W-1:0] imem_wdata,
  input  logic              redirect_valid,
  input  logic [PC_W-1:0]   redirect_pc,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [DATA_W-1:0] instr,
  output logic [PC_W-1:0]   instr_pc,
  output logic              halted
);

  logic [DATA_W-1:0] imem [IMEM_DEPTH];
  logic [PC_W-1:0]   pc;
  logic [DATA_W-1:0] rd_word;
  logic              pc_at_end;
  logic              space;
  logic              issue;
  fetch_state_e      state;
  fetch_state_e      state_nx;

  always_ff @(posedge clk) begin
    if (imem_we) imem[imem_waddr] <= imem_wdata;
  end

  always_comb begin
    rd_word   = imem[pc];
    pc_at_end = ({1'b0, pc} == prog_len);
    issue     = fetch_en && !halted && !redirect_valid && space && !pc_at_end;
  end

  always_ff @(posedge clk) begin
    if (rst)                 pc <= PC_W'(RESET_PC);
    else if (redirect_valid) pc <= redirect_pc;
    else if (issue)          pc <= pc + PC_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) state <= FETCH_RUN;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (redirect_valid)
      state_nx = FETCH_RUN;
    else if (state == FETCH_RUN && fetch_en && pc_at_end)
      state_nx = FETCH_HALT;
  end

  always_comb begin
    halted = (state == FETCH_HALT);
  end

`ifdef SKID_BUF_EN
  logic [1:0]             fifo_count;
  logic [DATA_W+PC_W-1:0] fifo_head;

  fetch_skid_fifo2 #(
    .W(DATA_W + PC_W)
  ) u_skid (
    .clk   (clk),
    .rst   (rst),
    .push  (issue),
    .din   ({rd_word, pc}),
    .pop   (instr_valid && instr_ready),
    .flush (redirect_valid),
    .dout  (fifo_head),
    .count (fifo_count)
  );

  // Space comes only from the registered count, keeping instr_ready off the issue path.
  always_comb begin
    space             = (fifo_count < 2'd2);
    instr_valid       = (fifo_count != 2'd0);
    {instr, instr_pc} = fifo_head;
  end
`else
  logic              out_valid;
  logic [DATA_W-1:0] out_instr;
  logic [PC_W-1:0]   out_pc;

  always_comb begin
    space       = !out_valid || instr_ready;
    instr_valid = out_valid;
    instr       = out_instr;
    instr_pc    = out_pc;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_instr <= DATA_W'(NOP_WORD);
      out_pc    <= PC_W'(RESET_PC);
    end else if (redirect_valid) begin
      out_valid <= 1'b0;
    end else if (issue) begin
      out_valid <= 1'b1;
      out_instr <= rd_word;
      out_pc    <= pc;
    end else if (out_valid && instr_ready) begin
      out_valid <= 1'b0;
    end
  end
`endif

endmodule
